// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, controller state encoding and default ULA pipeline latency
// shared by the ULA command-side controller and its users.
`default_nettype none

package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;

  localparam int ULA_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ula_ctrl.sv
// ula_ctrl: accepts one add/sub command, holds it on the ULA inputs for the
// pipeline latency, then returns the captured result on a valid/ready channel.
`default_nettype none

module ula_ctrl
  import ula_pkg::*;
#(
  parameter int ULA_LAT = ULA_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [2:0] ula_op,
  input  logic [7:0] ula_s,
  input  logic       ula_flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_s,
  output logic       res_flag,
  output logic       res_err,
  output logic [7:0] op_count
);

  localparam int CNT_W = ($clog2(ULA_LAT + 1) > 0) ? $clog2(ULA_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(ULA_LAT);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_ready;
  logic [7:0]       r_ula_a;
  logic [7:0]       r_ula_b;
  logic [2:0]       r_ula_op;
  logic             r_res_valid;
  logic [7:0]       r_res_s;
  logic             r_res_flag;
  logic             r_res_err;
  logic [7:0]       r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_ula_a     <= 8'd0;
      r_ula_b     <= 8'd0;
      r_ula_op    <= 3'd0;
      r_res_valid <= 1'b0;
      r_res_s     <= 8'd0;
      r_res_flag  <= 1'b0;
      r_res_err   <= 1'b0;
      r_op_count  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (op_supported(cmd_op)) begin
              r_ula_a  <= cmd_a;
              r_ula_b  <= cmd_b;
              r_ula_op <= cmd_op;
              r_cnt    <= '0;
              r_state  <= ST_WAIT;
            end else begin
              // Unsupported ops never reach the ULA; answer directly.
              r_res_err   <= 1'b1;
              r_res_s     <= 8'd0;
              r_res_flag  <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == c_CNT_LAST) begin
            r_res_s     <= ula_s;
            r_res_flag  <= ula_flag;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_op_count  <= r_op_count + 8'd1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign ula_a     = r_ula_a;
  assign ula_b     = r_ula_b;
  assign ula_op    = r_ula_op;
  assign res_valid = r_res_valid;
  assign res_s     = r_res_s;
  assign res_flag  = r_res_flag;
  assign res_err   = r_res_err;
  assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: drives ula_ctrl against a small ULA model and checks every cycle
// against a transaction-level reference of the controller.
`default_nettype none

module tb_ula_ctrl;
  import ula_pkg::*;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = 8'd0;
  logic [7:0] cmd_b = 8'd0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] ula_a;
  logic [7:0] ula_b;
  logic [2:0] ula_op;
  logic [7:0] ula_s;
  logic       ula_flag;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_s;
  logic       res_flag;
  logic       res_err;
  logic [7:0] op_count;

  int errors = 0;
  int checks = 0;

  ula_ctrl #(.ULA_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_s(ula_s), .ula_flag(ula_flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_s(res_s), .res_flag(res_flag), .res_err(res_err),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ULA: registered inputs, registered result, flag combinational from input registers.
  logic [7:0] u_ra = 8'd0, u_rb = 8'd0, u_s = 8'd0;
  logic [2:0] u_rop = 3'd0;
  always @(posedge clk) begin
    u_ra  <= ula_a;
    u_rb  <= ula_b;
    u_rop <= ula_op;
    u_s   <= (u_rop == OP_SUB) ? (u_ra - u_rb) : (u_ra + u_rb);
  end
  assign ula_s    = u_s;
  assign ula_flag = (u_rop == OP_SUB) ? (u_ra < u_rb) : (({1'b0, u_ra} + {1'b0, u_rb}) > 9'd255);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
    if (op == OP_SUB) return {(a < b), 8'(a - b)};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Transaction-level reference: tracks what the controller must present each cycle.
  logic       m_ready = 0, m_valid = 0, m_busy = 0, m_f = 0, m_e = 0;
  int         m_cd = 0;
  logic [7:0] m_s = 0, m_cnt = 0, m_ua = 0, m_ub = 0;
  logic [2:0] m_uop = 0;
  logic [8:0] m_pend = 0;

  logic [38:0] dut_vec, mdl_vec;
  assign dut_vec = {cmd_ready, res_valid, res_s, res_flag, res_err, op_count, ula_a, ula_b, ula_op};
  assign mdl_vec = {m_ready, m_valid, m_s, m_f, m_e, m_cnt, m_ua, m_ub, m_uop};

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_state", 64'(dut_vec), 64'd0);
      m_ready = 0; m_valid = 0; m_busy = 0; m_f = 0; m_e = 0; m_cd = 0;
      m_s = 0; m_cnt = 0; m_ua = 0; m_ub = 0; m_uop = 0;
    end else begin
      check("cycle_outputs", 64'(dut_vec), 64'(mdl_vec));
      if (m_valid) begin
        if (res_ready) begin
          m_valid = 0;
          m_ready = 1;
          m_cnt   = m_cnt + 8'd1;
        end
      end else if (m_busy) begin
        m_cd = m_cd - 1;
        if (m_cd == 0) begin
          m_busy  = 0;
          m_valid = 1;
          m_s     = m_pend[7:0];
          m_f     = m_pend[8];
          m_e     = 0;
        end
      end else if (m_ready) begin
        if (cmd_valid) begin
          m_ready = 0;
          if (cmd_op == OP_ADD || cmd_op == OP_SUB) begin
            m_ua   = cmd_a;
            m_ub   = cmd_b;
            m_uop  = cmd_op;
            m_pend = ref_result(cmd_a, cmd_b, cmd_op);
            m_busy = 1;
            m_cd   = LAT + 1;
          end else begin
            m_valid = 1;
            m_s = 0; m_f = 0; m_e = 1;
          end
        end
      end else begin
        m_ready = 1;
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit done = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) done = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 3'($urandom);
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got cmd_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_result(output int lat, output logic [7:0] s, output logic f, output logic e);
    bit got = 0;
    lat = 0; s = 0; f = 0; e = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1; lat = i; s = res_s; f = res_flag; e = res_err;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL result_timeout: got res_valid=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic respond();
    @(posedge clk); #1; res_ready = 1;
    @(posedge clk); #1; res_ready = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] s;
    logic       f, e;
    logic [2:0] op;

    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Test 1: basic add, latency and count.
    issue(8'h05, 8'h03, OP_ADD);
    wait_result(lat, s, f, e);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_result", {55'd0, s, f}, {55'd0, 8'h08, 1'b0});
    check("t1_err", 64'(e), 64'd0);
    respond();
    @(negedge clk);
    check("t1_count_ready", {55'd0, op_count, cmd_ready}, {55'd0, 8'd1, 1'b1});

    // Test 2: carry out and subtract.
    issue(8'hFF, 8'h01, OP_ADD);
    wait_result(lat, s, f, e);
    check("t2_add_carry", {55'd0, s, f}, {55'd0, 8'h00, 1'b1});
    respond();
    issue(8'h10, 8'h01, OP_SUB);
    wait_result(lat, s, f, e);
    check("t2_sub", {55'd0, s, f}, {55'd0, 8'h0F, 1'b0});
    respond();

    // Test 3: unsupported op answered next cycle, ULA lines untouched.
    issue(8'hAA, 8'hBB, 3'd5);
    wait_result(lat, s, f, e);
    check("t3_latency", 64'(lat), 64'd1);
    check("t3_err_result", {54'd0, e, s, f}, {54'd0, 1'b1, 8'h00, 1'b0});
    check("t3_ula_held", {45'd0, ula_a, ula_b, ula_op}, {45'd0, 8'h10, 8'h01, 3'd1});
    respond();

    // Test 4: back-pressure on the result.
    issue(8'h80, 8'h90, OP_ADD);
    wait_result(lat, s, f, e);
    for (int i = 0; i < 10; i++) begin
      check("t4_hold", {53'd0, res_valid, res_s, res_flag, cmd_ready},
            {53'd0, 1'b1, 8'h10, 1'b1, 1'b0});
      @(negedge clk);
    end
    respond();
    @(negedge clk);
    check("t4_release", {55'd0, op_count, cmd_ready}, {55'd0, 8'd5, 1'b1});

    // Test 5: reset while waiting on the ULA.
    issue(8'h33, 8'h44, OP_ADD);
    @(negedge clk);
    @(posedge clk); #2 rst_n = 0;
    #1 check("t5_async_reset", 64'(dut_vec), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_no_result", 64'(res_valid), 64'd0);
    end
    issue(8'h02, 8'h02, OP_ADD);
    wait_result(lat, s, f, e);
    check("t5_after_reset", {54'd0, e, s, f}, {54'd0, 1'b0, 8'h04, 1'b0});
    respond();

    // Test 6: 256 randomized ops with the consumer always ready.
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    res_ready = 1;
    for (int n = 0; n < 256; n++) begin
      if ($urandom_range(0, 7) == 0) op = 3'($urandom_range(2, 7));
      else                           op = 3'($urandom_range(0, 1));
      issue(8'($urandom), 8'($urandom), op);
    end
    repeat (8) @(negedge clk);
    check("t6_wrap", {55'd0, op_count, res_valid}, {55'd0, 8'h00, 1'b0});
    res_ready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
